cd_local_reply_sched: RTL

Sequencing/arbitration controller for the quadrant's LOCAL reply path (2 converged inputs → 4 routers). Buffers each converged reply flit in a 1-entry holding register and decodes its destination router from Hx/Hy. Arbitrates round-robin when both flits target the same router, and drives 4 registered valid/ready output ports toward the quadrant routers. Sits between global_xbar reply outputs and the local router injection ports.

---
 rtl/cd_local_reply_sched_pkg.sv | 32 +++
 rtl/cd_local_reply_select.sv | 49 ++++
 rtl/cd_local_reply_sched.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cd_local_reply_sched_pkg.sv
// Shared definitions for the quadrant LOCAL reply scheduler: default
// header field layout, quadrant router coordinates and the source encoding
// used by the per-router round-robin pointers.
package cd_local_reply_sched_pkg;

    // Flit and header layout defaults (shared with the select/xbar blocks)
    localparam int CD_DATA_W = 64;
    localparam int CD_HXO    = 55;
    localparam int CD_HXW    = 4;
    localparam int CD_HYO    = 51;
    localparam int CD_HYW    = 4;

    // Default coordinates of the four quadrant routers
    localparam int CD_RX0 = 0;
    localparam int CD_RY0 = 0;
    localparam int CD_RX1 = 1;
    localparam int CD_RY1 = 0;
    localparam int CD_RX2 = 0;
    localparam int CD_RY2 = 1;
    localparam int CD_RX3 = 1;
    localparam int CD_RY3 = 1;

    localparam int CD_CNT_W   = 8;
    localparam int CD_NUM_RTR = 4;

    // Round-robin pointer value: which converged input goes first on a tie
    typedef enum logic [0:0] {
        SRC_CV0 = 1'b0,
        SRC_CV1 = 1'b1
    } src_e;

endpackage

// File: rtl/cd_local_reply_select.sv
// Destination decode for the two holding registers: compares the Hx/Hy
// header fields against the four router coordinates and returns a one-hot
// router select per input (all-zero means no router matches).
module cd_local_reply_select
    import cd_local_reply_sched_pkg::*;
#(
    parameter int DATA_W = CD_DATA_W,
    parameter int HXO    = CD_HXO,
    parameter int HXW    = CD_HXW,
    parameter int HYO    = CD_HYO,
    parameter int HYW    = CD_HYW,
    parameter int RX0    = CD_RX0,
    parameter int RY0    = CD_RY0,
    parameter int RX1    = CD_RX1,
    parameter int RY1    = CD_RY1,
    parameter int RX2    = CD_RX2,
    parameter int RY2    = CD_RY2,
    parameter int RX3    = CD_RX3,
    parameter int RY3    = CD_RY3
) (
    input  logic [DATA_W-1:0] hold_d0,
    input  logic [DATA_W-1:0] hold_d1,
    output logic [3:0]        sel_cv0,
    output logic [3:0]        sel_cv1
);

    // Coordinates are distinct, so a multi-hot raw match can only come from
    // a bad parameter set; keep the lowest router in that case.
    function automatic logic [3:0] decode(input logic [DATA_W-1:0] d);
        logic [HXW-1:0] hx;
        logic [HYW-1:0] hy;
        logic [3:0]     raw;
        hx     = d[HXO -: HXW];
        hy     = d[HYO -: HYW];
        raw[0] = (int'(hx) == RX0) && (int'(hy) == RY0);
        raw[1] = (int'(hx) == RX1) && (int'(hy) == RY1);
        raw[2] = (int'(hx) == RX2) && (int'(hy) == RY2);
        raw[3] = (int'(hx) == RX3) && (int'(hy) == RY3);
        return raw & (~raw + 4'd1);
    endfunction

    assign sel_cv0 = decode(hold_d0);
    assign sel_cv1 = decode(hold_d1);

    // Payload bits outside the header fields play no part in routing
    logic unused_payload;
    assign unused_payload = ^{hold_d0, hold_d1};

endmodule

// File: rtl/cd_local_reply_sched.sv
// LOCAL reply scheduler: two converged reply inputs, each with a 1-entry
// holding register, routed to four quadrant router ports. Per-router
// round-robin between the inputs, registered valid/ready outputs, and a
// saturating counter of flits whose header matches no router.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid never depends on ready, data is stable while valid is
// high and ready low. cvK_ready depends combinationally on lo_ready so a
// holding register can drain and reload in the same cycle.
module cd_local_reply_sched
    import cd_local_reply_sched_pkg::*;
#(
    parameter int DATA_W = CD_DATA_W,
    parameter int HXO    = CD_HXO,
    parameter int HXW    = CD_HXW,
    parameter int HYO    = CD_HYO,
    parameter int HYW    = CD_HYW,
    parameter int RX0    = CD_RX0,
    parameter int RY0    = CD_RY0,
    parameter int RX1    = CD_RX1,
    parameter int RY1    = CD_RY1,
    parameter int RX2    = CD_RX2,
    parameter int RY2    = CD_RY2,
    parameter int RX3    = CD_RX3,
    parameter int RY3    = CD_RY3,
    parameter int CNT_W  = CD_CNT_W
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         cv0_valid,
    input  logic [DATA_W-1:0]            cv0_di,
    output logic                         cv0_ready,
    input  logic                         cv1_valid,
    input  logic [DATA_W-1:0]            cv1_di,
    output logic                         cv1_ready,
    output logic [CD_NUM_RTR-1:0]        lo_valid,
    output logic [CD_NUM_RTR*DATA_W-1:0] lo_do,
    input  logic [CD_NUM_RTR-1:0]        lo_ready,
    output logic [CNT_W-1:0]             drop_cnt
);

    localparam int NR = CD_NUM_RTR;

    logic [1:0]        hold_v;
    logic [DATA_W-1:0] hold_d0;
    logic [DATA_W-1:0] hold_d1;
    logic [NR-1:0]     out_v;
    logic [DATA_W-1:0] out_d [NR];
    logic [NR-1:0]     prio;

    logic [3:0]        sel_cv0;
    logic [3:0]        sel_cv1;
    logic [NR-1:0]     slot_free;
    logic [NR-1:0]     gnt0;
    logic [NR-1:0]     gnt1;
    logic              drop0;
    logic              drop1;
    logic              drain0;
    logic              drain1;
    logic [CNT_W:0]    cnt_sum;
    logic [CNT_W-1:0]  cnt_next;

    cd_local_reply_select #(
        .DATA_W (DATA_W),
        .HXO    (HXO),
        .HXW    (HXW),
        .HYO    (HYO),
        .HYW    (HYW),
        .RX0    (RX0),
        .RY0    (RY0),
        .RX1    (RX1),
        .RY1    (RY1),
        .RX2    (RX2),
        .RY2    (RY2),
        .RX3    (RX3),
        .RY3    (RY3)
    ) u_select (
        .hold_d0 (hold_d0),
        .hold_d1 (hold_d1),
        .sel_cv0 (sel_cv0),
        .sel_cv1 (sel_cv1)
    );

    // Per-router grant: a lone requester wins, a tie goes to prio[r]
    always_comb begin
        slot_free = ~out_v | lo_ready;
        gnt0      = '0;
        gnt1      = '0;
        for (int r = 0; r < NR; r++) begin
            if (slot_free[r]) begin
                if (hold_v[0] && sel_cv0[r] && hold_v[1] && sel_cv1[r]) begin
                    if (src_e'(prio[r]) == SRC_CV0) gnt0[r] = 1'b1;
                    else                            gnt1[r] = 1'b1;
                end else if (hold_v[0] && sel_cv0[r]) begin
                    gnt0[r] = 1'b1;
                end else if (hold_v[1] && sel_cv1[r]) begin
                    gnt1[r] = 1'b1;
                end
            end
        end
    end

    // Drain / drop detection, input ready and saturating drop increment
    always_comb begin
        drop0     = hold_v[0] && (sel_cv0 == 4'd0);
        drop1     = hold_v[1] && (sel_cv1 == 4'd0);
        drain0    = (|gnt0) || drop0;
        drain1    = (|gnt1) || drop1;
        cv0_ready = !reset && (!hold_v[0] || drain0);
        cv1_ready = !reset && (!hold_v[1] || drain1);
        cnt_sum   = {1'b0, drop_cnt} + (CNT_W+1)'(drop0) + (CNT_W+1)'(drop1);
        cnt_next  = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end

    // Holding registers: load on accept, otherwise empty on drain
    always_ff @(posedge clk) begin
        if (reset) begin
            hold_v  <= '0;
            hold_d0 <= '0;
            hold_d1 <= '0;
        end else begin
            if (cv0_valid && cv0_ready) begin
                hold_d0   <= cv0_di;
                hold_v[0] <= 1'b1;
            end else if (drain0) begin
                hold_v[0] <= 1'b0;
            end
            if (cv1_valid && cv1_ready) begin
                hold_d1   <= cv1_di;
                hold_v[1] <= 1'b1;
            end else if (drain1) begin
                hold_v[1] <= 1'b0;
            end
        end
    end

    // Output registers and round-robin pointers; data only moves on a grant
    always_ff @(posedge clk) begin
        if (reset) begin
            out_v <= '0;
            prio  <= '0;
            for (int r = 0; r < NR; r++) out_d[r] <= '0;
        end else begin
            for (int r = 0; r < NR; r++) begin
                if (gnt0[r]) begin
                    out_v[r] <= 1'b1;
                    out_d[r] <= hold_d0;
                    prio[r]  <= SRC_CV1;
                end else if (gnt1[r]) begin
                    out_v[r] <= 1'b1;
                    out_d[r] <= hold_d1;
                    prio[r]  <= SRC_CV0;
                end else if (lo_ready[r]) begin
                    out_v[r] <= 1'b0;
                end
            end
        end
    end

    // Drop counter; flits discarded by reset are not counted
    always_ff @(posedge clk) begin
        if (reset) drop_cnt <= '0;
        else       drop_cnt <= cnt_next;
    end

    // Output packing; valid is masked in the reset cycle so no handshake completes
    always_comb begin
        lo_valid = out_v & {NR{!reset}};
        lo_do    = '0;
        for (int r = 0; r < NR; r++) lo_do[r*DATA_W +: DATA_W] = out_d[r];
    end

endmodule
